// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared widths, the EXE->MEM payload layout and the load extension helpers
//   used by the memory-access stage.
//   Contents:
//     ES_TO_MS_BUS_WD / MS_TO_WS_BUS_WD / MS_FWD_WD  bus widths
//     es_payload_t                                   field view of es_to_ms_bus
//     ext_byte / ext_half                            sign- or zero-extension
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 77;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_FWD_WD       = 38;

  // Field order matches the concatenation EXE builds, MSB first.
  typedef struct packed {
    logic        mem_req;
    logic        ld_b;
    logic        ld_bu;
    logic        ld_h;
    logic        ld_hu;
    logic        ld_w;
    logic [31:0] pc;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] exe_result;
  } es_payload_t;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if
//   Pipeline handshake between EXE, MEM and WB as seen by the memory stage.
//   master : the surrounding pipeline (drives EXE payload and WB allowin)
//   slave  : mem_stage
//   Signals:
//     es_to_ms_valid/bus/excp/excp_hit  EXE payload into MEM
//     ms_allowin                        MEM can accept a payload
//     ms_to_ws_valid/bus/excp           MEM payload into WB
//     ws_allowin                        WB can accept
interface mem_stage_if import mem_stage_pkg::*; #(
  parameter int EXC_W = 128
) ();

  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [EXC_W-1:0]           es_to_ms_excp;
  logic                       es_to_ms_excp_hit;
  logic                       ms_allowin;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [EXC_W-1:0]           ms_to_ws_excp;
  logic                       ws_allowin;

  modport master (
    output es_to_ms_valid, es_to_ms_bus, es_to_ms_excp, es_to_ms_excp_hit, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ws_excp
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, es_to_ms_excp, es_to_ms_excp_hit, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ws_excp
  );

endinterface

// File: rtl/mem_load_align.sv
// mem_load_align
//   Combinational load data alignment: picks the byte/half addressed by the
//   low address bits out of the response word and extends it to 32 bits.
//   Ports:
//     rdata   in  32  response word (live or buffered)
//     off     in  2   address bits [1:0]
//     ld_*    in  1   one-hot load kind
//     result  out 32  aligned, extended load value
module mem_load_align import mem_stage_pkg::*; (
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic        ld_b,
  input  logic        ld_bu,
  input  logic        ld_h,
  input  logic        ld_hu,
  input  logic        ld_w,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select addressed byte/half, then extend according to the load kind.
  always_comb begin
    case (off)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    half_s = off[1] ? rdata[31:16] : rdata[15:0];

    if (ld_b | ld_bu) begin
      result = ext_byte(byte_s, ld_b);
    end else if (ld_h | ld_hu) begin
      result = ext_half(half_s, ld_h);
    end else if (ld_w) begin
      result = rdata;
    end else begin
      result = 32'd0;
    end
  end

endmodule

// File: rtl/mem_stage_chk.sv
// mem_stage_chk
//   Simulation checks for mem_stage internals.
//   Ports:
//     clk, resetn   clock and active-low reset
//     cancel_cnt    outstanding stale-response count
//     cancel_inc    a flush is abandoning an in-flight request this cycle
//     stale_ok      a stale response is being discarded this cycle
module mem_stage_chk #(
  parameter int CANCEL_W = 2
) (
  input logic                clk,
  input logic                resetn,
  input logic [CANCEL_W-1:0] cancel_cnt,
  input logic                cancel_inc,
  input logic                stale_ok
);

  localparam logic [CANCEL_W-1:0] CANCEL_MAX = {CANCEL_W{1'b1}};

  // Losing an increment would hand a stale response to a later instruction.
  cancel_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(cancel_inc && !stale_ok && (cancel_cnt == CANCEL_MAX)));

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access pipeline stage. Holds one instruction, waits for the data
//   response of its load/store, aligns load data and forwards to WB.
//   Responses still owed to flushed instructions are counted and discarded.
//   Ports:
//     clk, resetn          clock, async active-low reset
//     pipe (slave)         EXE->MEM and MEM->WB handshake/payload
//     data_sram_data_ok    response valid (in request order)
//     data_sram_rdata      response data
//     ms_flush             WB flush, kills MEM contents
//     ms_to_es_excp        MEM holds an excepting instr (EXE blocks stores)
//     ms_fwd               {valid&rf_we, rf_waddr, final_result} to ID
//     ms_ld_pending        load still waiting; ID must stall
module mem_stage import mem_stage_pkg::*; #(
  parameter int EXC_W    = 128,
  parameter int CANCEL_W = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  mem_stage_if.slave           pipe,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 ms_flush,
  output logic                 ms_to_es_excp,
  output logic [MS_FWD_WD-1:0] ms_fwd,
  output logic                 ms_ld_pending
);

  localparam logic [CANCEL_W-1:0] CANCEL_MAX  = {CANCEL_W{1'b1}};
  localparam logic [CANCEL_W-1:0] CANCEL_ZERO = {CANCEL_W{1'b0}};
  localparam logic [CANCEL_W-1:0] CANCEL_ONE  = CANCEL_W'(1'b1);

  logic                ms_valid_q, ms_valid_d;
  es_payload_t         payload_q, payload_d;
  logic [EXC_W-1:0]    excp_q, excp_d;
  logic                excp_hit_q, excp_hit_d;
  logic [31:0]         buf_q, buf_d;
  logic                buf_valid_q, buf_valid_d;
  logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;

  logic        no_stale_s;
  logic        stale_ok_s;
  logic        owned_ok_s;
  logic        ready_go_s;
  logic        to_ws_valid_s;
  logic        capture_s;
  logic        leave_s;
  logic        cancel_inc_s;
  logic [31:0] rdata_sel_s;
  logic [31:0] aligned_s;
  logic [31:0] final_result_s;

  // Responses arrive in order, so any pending cancel count means the current
  // data_ok belongs to an already-flushed instruction.
  assign no_stale_s = (cancel_cnt_q == CANCEL_ZERO);
  assign stale_ok_s = data_sram_data_ok & ~no_stale_s;
  assign owned_ok_s = data_sram_data_ok & no_stale_s & ms_valid_q
                    & payload_q.mem_req & ~buf_valid_q;

  assign ready_go_s    = ~payload_q.mem_req | buf_valid_q | (data_sram_data_ok & no_stale_s);
  assign to_ws_valid_s = ms_valid_q & ready_go_s & ~ms_flush;
  assign pipe.ms_allowin = ~ms_valid_q | (ready_go_s & pipe.ws_allowin) | ms_flush;
  assign capture_s     = pipe.es_to_ms_valid & pipe.ms_allowin;
  assign leave_s       = to_ws_valid_s & pipe.ws_allowin;

  // A flush abandons a request whose response has not yet been seen.
  assign cancel_inc_s = ms_flush & ms_valid_q & payload_q.mem_req & ~buf_valid_q & ~owned_ok_s;

  assign rdata_sel_s = buf_valid_q ? buf_q : data_sram_rdata;

  mem_load_align u_align (
    .rdata  (rdata_sel_s),
    .off    (payload_q.exe_result[1:0]),
    .ld_b   (payload_q.ld_b),
    .ld_bu  (payload_q.ld_bu),
    .ld_h   (payload_q.ld_h),
    .ld_hu  (payload_q.ld_hu),
    .ld_w   (payload_q.ld_w),
    .result (aligned_s)
  );

  assign final_result_s = payload_q.res_from_mem ? aligned_s : payload_q.exe_result;

  assign pipe.ms_to_ws_valid = to_ws_valid_s;
  assign pipe.ms_to_ws_bus   = {payload_q.pc, payload_q.rf_we, payload_q.rf_waddr, final_result_s};
  assign pipe.ms_to_ws_excp  = excp_q;
  assign ms_to_es_excp       = ms_valid_q & excp_hit_q;
  assign ms_fwd              = {ms_valid_q & payload_q.rf_we, payload_q.rf_waddr, final_result_s};
  assign ms_ld_pending       = ms_valid_q & payload_q.res_from_mem & ~ready_go_s;

  // Stage occupancy and payload capture.
  always_comb begin
    ms_valid_d = ms_valid_q;
    payload_d  = payload_q;
    excp_d     = excp_q;
    excp_hit_d = excp_hit_q;
    if (capture_s) begin
      ms_valid_d = 1'b1;
      payload_d  = es_payload_t'(pipe.es_to_ms_bus);
      excp_d     = pipe.es_to_ms_excp;
      excp_hit_d = pipe.es_to_ms_excp_hit;
    end else if (ms_flush | leave_s) begin
      ms_valid_d = 1'b0;
    end else begin
      ms_valid_d = ms_valid_q;
    end
  end

  // Hold an owned response while WB is stalled so it is not lost.
  always_comb begin
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    if (ms_flush | leave_s) begin
      buf_valid_d = 1'b0;
    end else if (owned_ok_s & ~pipe.ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_d       = data_sram_rdata;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  // Stale-response counter; a simultaneous increment and discard cancel out.
  always_comb begin
    case ({cancel_inc_s, stale_ok_s})
      2'b10:   cancel_cnt_d = (cancel_cnt_q == CANCEL_MAX) ? cancel_cnt_q : cancel_cnt_q + CANCEL_ONE;
      2'b01:   cancel_cnt_d = cancel_cnt_q - CANCEL_ONE;
      default: cancel_cnt_d = cancel_cnt_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q   <= 1'b0;
      payload_q    <= '0;
      excp_q       <= '0;
      excp_hit_q   <= 1'b0;
      buf_q        <= 32'd0;
      buf_valid_q  <= 1'b0;
      cancel_cnt_q <= CANCEL_ZERO;
    end else begin
      ms_valid_q   <= ms_valid_d;
      payload_q    <= payload_d;
      excp_q       <= excp_d;
      excp_hit_q   <= excp_hit_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  mem_stage_chk #(.CANCEL_W(CANCEL_W)) u_chk (
    .clk        (clk),
    .resetn     (resetn),
    .cancel_cnt (cancel_cnt_q),
    .cancel_inc (cancel_inc_s),
    .stale_ok   (stale_ok_s)
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Directed and randomized checks of mem_stage against a small behavioural
//   model of load alignment and instruction flow.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        resetn;
  logic        data_ok;
  logic [31:0] rdata;
  logic        ms_flush;
  logic        ms_to_es_excp;
  logic [37:0] ms_fwd;
  logic        ms_ld_pending;

  int passed = 0;
  int total  = 0;

  mem_stage_if #(.EXC_W(128)) bus_if ();

  mem_stage #(.EXC_W(128), .CANCEL_W(2)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .pipe              (bus_if.slave),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .ms_flush          (ms_flush),
    .ms_to_es_excp     (ms_to_es_excp),
    .ms_fwd            (ms_fwd),
    .ms_ld_pending     (ms_ld_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 ld_b, 1 ld_bu, 2 ld_h, 3 ld_hu, 4 ld_w
  function automatic logic [31:0] ref_load(input int kind, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] x;
    case (kind)
      0, 1: begin
        x = (w >> (8 * off)) & 32'h0000_00FF;
        if (kind == 0 && x >= 32'h0000_0080) x = x - 32'h0000_0100;
      end
      2, 3: begin
        x = (w >> (16 * off[1])) & 32'h0000_FFFF;
        if (kind == 2 && x >= 32'h0000_8000) x = x - 32'h0001_0000;
      end
      default: x = w;
    endcase
    return x;
  endfunction

  function automatic logic [76:0] mk_bus(input logic mreq, input logic [4:0] ld, input logic [31:0] pc,
                                        input logic rfm, input logic we, input logic [4:0] wa,
                                        input logic [31:0] res);
    return {mreq, ld, pc, rfm, we, wa, res};
  endfunction

  function automatic logic [4:0] ld_flags(input int kind);
    logic [4:0] one;
    one = 5'b10000;
    return one >> kind;
  endfunction

  task automatic issue(input logic [76:0] b, input logic [127:0] ex, input logic hit);
    bus_if.es_to_ms_valid    = 1'b1;
    bus_if.es_to_ms_bus      = b;
    bus_if.es_to_ms_excp     = ex;
    bus_if.es_to_ms_excp_hit = hit;
    #1;
    chk("issue_allowin", bus_if.ms_allowin, 1'b1);
    step();
    bus_if.es_to_ms_valid    = 1'b0;
    bus_if.es_to_ms_excp_hit = 1'b0;
  endtask

  // One instruction through MEM: lat cycles to response, stall cycles of WB backpressure.
  task automatic run_instr(input logic [76:0] b, input logic [31:0] exp_res, input int lat,
                           input int stall, input logic [31:0] rd);
    logic [69:0] exp_bus;
    exp_bus = {b[70:39], b[37], b[36:32], exp_res};
    bus_if.ws_allowin = (stall == 0);
    issue(b, 128'd0, 1'b0);
    if (b[76]) begin
      for (int i = 1; i < lat; i++) begin
        #1;
        chk("wait_valid", bus_if.ms_to_ws_valid, 1'b0);
        chk("wait_pending", ms_ld_pending, b[38]);
        step();
      end
      data_ok = 1'b1;
      rdata   = rd;
    end
    #1;
    chk("out_valid", bus_if.ms_to_ws_valid, 1'b1);
    chk("out_bus", bus_if.ms_to_ws_bus, exp_bus);
    chk("out_pending", ms_ld_pending, 1'b0);
    step();
    data_ok = 1'b0;
    rdata   = ~rd;
    for (int k = 0; k < stall; k++) begin
      if (k == stall - 1) bus_if.ws_allowin = 1'b1;
      #1;
      chk("held_valid", bus_if.ms_to_ws_valid, 1'b1);
      chk("held_bus", bus_if.ms_to_ws_bus, exp_bus);
      step();
    end
    #1;
    chk("left_valid", bus_if.ms_to_ws_valid, 1'b0);
  endtask

  initial begin
    logic [76:0]  b;
    logic [127:0] ex;
    logic [31:0]  exe, rd, pc, expv;
    int           kind;

    resetn = 1'b0; data_ok = 1'b0; rdata = 32'd0; ms_flush = 1'b0;
    bus_if.es_to_ms_valid = 1'b0; bus_if.es_to_ms_bus = '0; bus_if.es_to_ms_excp = '0;
    bus_if.es_to_ms_excp_hit = 1'b0; bus_if.ws_allowin = 1'b1;
    #12;
    chk("rst_valid", bus_if.ms_to_ws_valid, 1'b0);
    chk("rst_allowin", bus_if.ms_allowin, 1'b1);
    chk("rst_bus", bus_if.ms_to_ws_bus, 70'd0);
    chk("rst_excp", bus_if.ms_to_ws_excp, 128'd0);
    chk("rst_to_es", ms_to_es_excp, 1'b0);
    chk("rst_fwd", ms_fwd, 38'd0);
    chk("rst_pending", ms_ld_pending, 1'b0);
    resetn = 1'b1;
    step();

    // ld_w at 0x1000 with a two-cycle response.
    run_instr(mk_bus(1'b1, ld_flags(4), 32'h0000_0100, 1'b1, 1'b1, 5'd3, 32'h0000_1000),
              32'h8765_4321, 2, 0, 32'h8765_4321);
    // Byte/half alignment and extension.
    run_instr(mk_bus(1'b1, ld_flags(0), 32'h0000_0104, 1'b1, 1'b1, 5'd4, 32'h0000_1003),
              32'hFFFF_FF80, 1, 0, 32'h8012_3456);
    run_instr(mk_bus(1'b1, ld_flags(1), 32'h0000_0108, 1'b1, 1'b1, 5'd5, 32'h0000_1003),
              32'h0000_0080, 1, 0, 32'h8012_3456);
    run_instr(mk_bus(1'b1, ld_flags(3), 32'h0000_010C, 1'b1, 1'b1, 5'd6, 32'h0000_1002),
              32'h0000_BEEF, 1, 0, 32'hBEEF_0000);
    // Response buffered while WB holds off for three cycles.
    run_instr(mk_bus(1'b1, ld_flags(4), 32'h0000_0110, 1'b1, 1'b1, 5'd7, 32'h0000_1004),
              32'hA5A5_A5A5, 1, 3, 32'hA5A5_A5A5);

    // Flush a waiting load; its late response must be dropped.
    bus_if.ws_allowin = 1'b1;
    issue(mk_bus(1'b1, ld_flags(4), 32'h0000_0200, 1'b1, 1'b1, 5'd8, 32'h0000_1000), 128'd0, 1'b0);
    ms_flush = 1'b1;
    #1;
    chk("flush_valid", bus_if.ms_to_ws_valid, 1'b0);
    chk("flush_allowin", bus_if.ms_allowin, 1'b1);
    step();
    ms_flush = 1'b0;
    #1;
    chk("flushed_fwd_we", ms_fwd[37], 1'b0);
    issue(mk_bus(1'b1, ld_flags(4), 32'h0000_0204, 1'b1, 1'b1, 5'd9, 32'h0000_2000), 128'd0, 1'b0);
    data_ok = 1'b1; rdata = 32'h0000_DEAD;
    #1;
    chk("stale_valid", bus_if.ms_to_ws_valid, 1'b0);
    chk("stale_pending", ms_ld_pending, 1'b1);
    step();
    rdata = 32'h0000_1234;
    #1;
    chk("after_stale_valid", bus_if.ms_to_ws_valid, 1'b1);
    chk("after_stale_bus", bus_if.ms_to_ws_bus, {32'h0000_0204, 1'b1, 5'd9, 32'h0000_1234});
    step();
    data_ok = 1'b0;
    #1;
    chk("after_stale_left", bus_if.ms_to_ws_valid, 1'b0);

    // Flush in the same cycle as the owned response: nothing left outstanding.
    issue(mk_bus(1'b1, ld_flags(4), 32'h0000_0300, 1'b1, 1'b1, 5'd10, 32'h0000_3000), 128'd0, 1'b0);
    data_ok = 1'b1; rdata = 32'h1111_2222; ms_flush = 1'b1;
    #1;
    chk("flush_ok_valid", bus_if.ms_to_ws_valid, 1'b0);
    step();
    data_ok = 1'b0; ms_flush = 1'b0;
    #1;
    chk("flush_ok_fwd_we", ms_fwd[37], 1'b0);
    run_instr(mk_bus(1'b1, ld_flags(4), 32'h0000_0304, 1'b1, 1'b1, 5'd11, 32'h0000_3004),
              32'h0000_0055, 1, 0, 32'h0000_0055);

    // Excepting instruction: no memory wait, exception bus passed through.
    ex = {$urandom, $urandom, $urandom, $urandom};
    b  = mk_bus(1'b0, 5'd0, 32'h0000_0400, 1'b0, 1'b1, 5'd12, 32'hCAFE_0000);
    #1;
    chk("pre_excp_to_es", ms_to_es_excp, 1'b0);
    issue(b, ex, 1'b1);
    #1;
    chk("excp_to_es", ms_to_es_excp, 1'b1);
    chk("excp_valid", bus_if.ms_to_ws_valid, 1'b1);
    chk("excp_bus", bus_if.ms_to_ws_excp, ex);
    chk("excp_wb_bus", bus_if.ms_to_ws_bus, {32'h0000_0400, 1'b1, 5'd12, 32'hCAFE_0000});
    step();
    #1;
    chk("excp_left_to_es", ms_to_es_excp, 1'b0);

    // Reset while a load is waiting.
    issue(mk_bus(1'b1, ld_flags(4), 32'h0000_0500, 1'b1, 1'b1, 5'd13, 32'h0000_5000), ex, 1'b0);
    #1;
    chk("pre_rst_pending", ms_ld_pending, 1'b1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", bus_if.ms_to_ws_valid, 1'b0);
    chk("mid_rst_bus", bus_if.ms_to_ws_bus, 70'd0);
    chk("mid_rst_excp", bus_if.ms_to_ws_excp, 128'd0);
    chk("mid_rst_fwd", ms_fwd, 38'd0);
    chk("mid_rst_pending", ms_ld_pending, 1'b0);
    #2;
    resetn = 1'b1;
    step();
    run_instr(mk_bus(1'b1, ld_flags(4), 32'h0000_0504, 1'b1, 1'b1, 5'd14, 32'h0000_5004),
              32'h0BAD_F00D, 1, 0, 32'h0BAD_F00D);

    // Randomized mix of loads, stores and ALU results.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 6);
      exe  = $urandom;
      rd   = $urandom;
      pc   = $urandom;
      if (kind <= 4) begin
        b    = mk_bus(1'b1, ld_flags(kind), pc, 1'b1, 1'b1, 5'($urandom), exe);
        expv = ref_load(kind, exe[1:0], rd);
      end else if (kind == 5) begin
        b    = mk_bus(1'b0, 5'd0, pc, 1'b0, 1'($urandom), 5'($urandom), exe);
        expv = exe;
      end else begin
        b    = mk_bus(1'b1, 5'd0, pc, 1'b0, 1'b0, 5'($urandom), exe);
        expv = exe;
      end
      run_instr(b, expv, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)), rd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
